sram_rw_port_ctrl: RTL



---
 rtl/sram_rw_port_ctrl_if.sv | 40 ++++
 rtl/sram_rw_port_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sram_rw_port_ctrl_if.sv
// Request, response and macro-pin bundle for sram_rw_port_ctrl.
// Latency: none, this file only groups signals.
// Backpressure: req_valid/req_ready for requests and resp_valid/resp_ready for read responses.
// Ports:
//   req_*   masked-write / read request stream.
//   resp_*  in-order read data.
//   RW0_*   single-port SRAM macro pins. RW0_rdata is valid the cycle after a read.
// Modports:
//   master  the requester together with the attached macro.
//   slave   the controller.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [DATA_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, RW0_rdata,
    input  req_ready, resp_valid, resp_rdata, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, RW0_rdata,
    output req_ready, resp_valid, resp_rdata, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Request-side controller for a single-port SRAM macro with a 1-cycle read and a per-bit write mask.
// Latency: a write reaches the macro combinationally in the accept cycle. A read accepted at T gives resp_valid at T+2.
// Backpressure: req_ready is a credit check on (fifo count + in-flight read) < 3, and resp_ready pops the 3-entry FIFO.
// Ports:
//   clock    Clock for the controller and the attached macro.
//   reset_n  Asynchronous active-low reset.
//   bus      sram_rw_port_ctrl_if.slave, carrying the req_*, resp_* and RW0_* signals.
//   init_done  High once the array is ready for traffic.
// Option: SRAM_INIT_CLEAR_EN. When it is defined, all DEPTH words are written to zero after reset, before any traffic is accepted.
module sram_rw_port_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512
) (
  input  logic               clock,
  input  logic               reset_n,
  sram_rw_port_ctrl_if.slave bus,
  output logic               init_done
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("sram_rw_port_ctrl: DEPTH does not fit in ADDR_W address bits");
  end

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
`ifdef SRAM_INIT_CLEAR_EN
    ST_CLEAR = 2'd1,
`endif
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Response FIFO state. The pointers wrap at 3, and the count ranges over 0..3.
  logic [DATA_W-1:0] fifo_mem [3];
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;
  logic              inflight_q;   // A read was issued in the previous cycle.
  logic              accept, push, pop, credit_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count only reads: buffered entries plus the one whose data is on RW0_rdata now.
  assign credit_ok       = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
  assign push            = inflight_q;
  assign pop             = bus.resp_valid && bus.resp_ready;
  assign bus.resp_valid  = (count_q != 2'd0);
  assign bus.resp_rdata  = fifo_mem[rd_ptr_q];

`ifdef SRAM_INIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= (clr_addr_q == CLR_LAST) ? '0 : clr_addr_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    init_done     = 1'b0;
    bus.req_ready = 1'b0;
    bus.RW0_en    = 1'b0;
    bus.RW0_wmode = 1'b0;
    bus.RW0_addr  = bus.req_addr;
    bus.RW0_wmask = bus.req_wmask;
    bus.RW0_wdata = bus.req_wdata;
    case (state_q)
      ST_BOOT: begin
`ifdef SRAM_INIT_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_RUN;
`endif
      end
`ifdef SRAM_INIT_CLEAR_EN
      ST_CLEAR: begin
        bus.RW0_en    = 1'b1;
        bus.RW0_wmode = 1'b1;
        bus.RW0_addr  = clr_addr_q;
        bus.RW0_wmask = '1;
        bus.RW0_wdata = '0;
        if (clr_addr_q == CLR_LAST) state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        init_done     = 1'b1;
        bus.req_ready = credit_ok;
        accept        = bus.req_valid && credit_ok;
        bus.RW0_en    = accept;
        bus.RW0_wmode = bus.req_write;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= accept && !bus.req_write;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Macro read data is valid for exactly one cycle, so it is captured unconditionally.
  // The credit check guarantees that a free slot exists.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.RW0_rdata;
  end

endmodule
